// File: rtl/smi_pkg.sv
// Shared definitions for the SMI FIFO reader: FSM encoding, word geometry,
// channel codes and a byte-select helper.
package smi_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Channel codes for i_channel_sel and the latched active channel.
    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULL  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SHIFT = 3'd4
    } smi_state_t;

    // Byte idx of a 32-bit word, LSB byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return 8'(word >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/smi_strobe_sync.sv
// Synchronizer and rising-edge detector for the active-low SMI read strobe.
// The edge marks the end of a host byte read; o_rise is a one-cycle pulse.
module smi_strobe_sync #(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic i_sys_clk,
    input  logic i_reset_n,
    input  logic i_strobe_n,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw strobe through the synchronizer and keep the previous synchronized value.
    always_ff @(posedge i_sys_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
        if (!i_reset_n) begin
            // Reset to the inactive (high) level so release never looks like a rising edge.
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe_n};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/smi_fifo_reader.sv
// Reads 32-bit words from one of two FIFOs and presents them byte by byte
// (LSB first) on the SMI bus, advancing on each end-of-read strobe edge.
module smi_fifo_reader
    import smi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic        i_channel_sel,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_pulled_data,
    input  logic        i_fifo_09_empty,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_pulled_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_smi_soe_se,
    output logic [7:0]  o_smi_data_out,
    output logic        o_smi_read_req,
    input  logic        i_underrun_clr,
    output logic        o_underrun
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    smi_state_t  r_state;
    logic        r_channel;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [7:0]  r_data_out;
    logic        r_read_req;
    logic        r_pull_09;
    logic        r_pull_24;
    logic        r_underrun;

    logic        w_strobe_rise;
    logic        w_sel_empty;

    smi_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .i_sys_clk  (i_sys_clk),
        .i_reset_n  (i_reset_n),
        .i_strobe_n (i_smi_soe_se),
        .o_rise     (w_strobe_rise)
    );

    // Empty flag of the FIFO the selector currently points at, used when choosing the next word.
    assign w_sel_empty = (i_channel_sel == CH_24) ? i_fifo_24_empty : i_fifo_09_empty;

    // Main FSM with registered pulls, byte output, read request and sticky underrun.
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_channel  <= CH_09;
            r_word     <= '0;
            r_idx      <= '0;
            r_data_out <= '0;
            r_read_req <= 1'b0;
            r_pull_09  <= 1'b0;
            r_pull_24  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            // NOTE: pulls default low every cycle so a pull is high only in the PULL state.
            r_pull_09 <= 1'b0;
            r_pull_24 <= 1'b0;

            // A host read with no word loaded is an underrun; setting beats clearing.
            if (w_strobe_rise && (r_state != ST_SHIFT)) begin
                r_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_channel <= i_channel_sel;
                    if (!w_sel_empty) begin
                        r_state   <= ST_PULL;
                        r_pull_09 <= (i_channel_sel == CH_09);
                        r_pull_24 <= (i_channel_sel == CH_24);
                    end
                end

                ST_PULL: begin
                    r_state <= ST_WAIT;
                end

                // FIFO data is valid now; the word lands as the FSM enters LOAD.
                ST_WAIT: begin
                    r_word     <= (r_channel == CH_24) ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
                    r_idx      <= '0;
                    r_read_req <= 1'b1;
                    r_state    <= ST_LOAD;
                end

                ST_LOAD: begin
                    r_data_out <= word_byte(r_word, 2'd0);
                    r_state    <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (w_strobe_rise) begin
                        if (r_idx == LAST_IDX) begin
                            // Word boundary: the only place the channel selector is honoured.
                            r_read_req <= 1'b0;
                            r_data_out <= '0;
                            r_idx      <= '0;
                            r_channel  <= i_channel_sel;
                            if (!w_sel_empty) begin
                                r_state   <= ST_PULL;
                                r_pull_09 <= (i_channel_sel == CH_09);
                                r_pull_24 <= (i_channel_sel == CH_24);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_data_out <= word_byte(r_word, r_idx + 2'd1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_fifo_09_pull = r_pull_09;
    assign o_fifo_24_pull = r_pull_24;
    assign o_smi_data_out = r_data_out;
    assign o_smi_read_req = r_read_req;
    assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_smi_fifo_reader.sv
// Self-checking bench for smi_fifo_reader: behavioural FIFOs, a strobing host
// and a scoreboard of expected bytes.
module tb_smi_fifo_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        channel_sel;
    logic        fifo09_pull;
    logic [31:0] fifo09_data;
    logic        fifo09_empty;
    logic        fifo24_pull;
    logic [31:0] fifo24_data;
    logic        fifo24_empty;
    logic        soe_n;
    logic [7:0]  data_out;
    logic        read_req;
    logic        underrun_clr;
    logic        underrun;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pulls09  = 0;
    int          pulls24  = 0;

    logic [31:0] q09[$];
    logic [31:0] q24[$];
    logic [7:0]  exp_q[$];

    smi_fifo_reader #(
        .SYNC_STAGES (2)
    ) dut (
        .i_sys_clk             (clk),
        .i_reset_n             (reset_n),
        .i_channel_sel         (channel_sel),
        .o_fifo_09_pull        (fifo09_pull),
        .i_fifo_09_pulled_data (fifo09_data),
        .i_fifo_09_empty       (fifo09_empty),
        .o_fifo_24_pull        (fifo24_pull),
        .i_fifo_24_pulled_data (fifo24_data),
        .i_fifo_24_empty       (fifo24_empty),
        .i_smi_soe_se          (soe_n),
        .o_smi_data_out        (data_out),
        .o_smi_read_req        (read_req),
        .i_underrun_clr        (underrun_clr),
        .o_underrun            (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Behavioural FIFOs: a pull seen at this negedge pops the head onto the data bus.
    always @(negedge clk) begin
        if (fifo09_pull || fifo24_pull) begin
            check("pull_exclusive", 32'(fifo09_pull & fifo24_pull), 32'd0);
        end
        if (fifo09_pull) begin
            pulls09++;
            check("pull09_nonempty", 32'(q09.size() != 0), 32'd1);
            if (q09.size() != 0) fifo09_data = q09.pop_front();
        end
        if (fifo24_pull) begin
            pulls24++;
            check("pull24_nonempty", 32'(q24.size() != 0), 32'd1);
            if (q24.size() != 0) fifo24_data = q24.pop_front();
        end
        fifo09_empty = (q09.size() == 0);
        fifo24_empty = (q24.size() == 0);
    end

    task automatic load(input logic ch, input logic [31:0] w);
        if (ch) begin
            q24.push_back(w);
            fifo24_empty = 1'b0;
        end else begin
            q09.push_back(w);
            fifo09_empty = 1'b0;
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            if (read_req) break;
            @(negedge clk);
        end
        check("req_wait", 32'(read_req), 32'd1);
    endtask

    // One host byte read: strobe low, sample the byte, raise strobe, let it settle.
    task automatic strobe_byte();
        logic [7:0] want;
        soe_n = 1'b0;
        repeat (3) @(negedge clk);
        want = 8'h00;
        if (exp_q.size() != 0) want = exp_q.pop_front();
        check("byte_req", 32'(read_req), 32'd1);
        check("byte", 32'(data_out), 32'(want));
        soe_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},  32'(read_req), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        int base09;
        int base24;

        reset_n      = 1'b0;
        channel_sel  = 1'b0;
        soe_n        = 1'b1;
        underrun_clr = 1'b0;
        fifo09_data  = '0;
        fifo24_data  = '0;
        fifo09_empty = 1'b1;
        fifo24_empty = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_data",     32'(data_out),    32'd0);
        check("rst_req",      32'(read_req),    32'd0);
        check("rst_underrun", 32'(underrun),    32'd0);
        check("rst_pull09",   32'(fifo09_pull), 32'd0);
        check("rst_pull24",   32'(fifo24_pull), 32'd0);

        // Single word from the 0.9 GHz FIFO, with latency checked cycle by cycle.
        load(1'b0, 32'hA1B2C3D4);
        expect_word(32'hA1B2C3D4);
        reset_n = 1'b1;
        @(negedge clk);
        check("lat_c1_pull09", 32'(fifo09_pull), 32'd1);
        check("lat_c1_req",    32'(read_req),    32'd0);
        @(negedge clk);
        check("lat_c2_pull09", 32'(fifo09_pull), 32'd0);
        check("lat_c2_req",    32'(read_req),    32'd0);
        @(negedge clk);
        check("lat_c3_req",    32'(read_req),    32'd1);
        repeat (4) strobe_byte();
        check_idle("t1_end");
        check("t1_pulls09", 32'(pulls09), 32'd1);
        check("t1_pulls24", 32'(pulls24), 32'd0);
        check("t1_underrun", 32'(underrun), 32'd0);

        // Two back-to-back words from the 2.4 GHz FIFO.
        base09 = pulls09;
        base24 = pulls24;
        channel_sel = 1'b1;
        load(1'b1, 32'h11223344);
        load(1'b1, 32'h55667788);
        expect_word(32'h11223344);
        expect_word(32'h55667788);
        wait_req();
        repeat (8) strobe_byte();
        repeat (4) @(negedge clk);
        check_idle("t2_end");
        check("t2_pulls24", 32'(pulls24 - base24), 32'd2);
        check("t2_pulls09", 32'(pulls09 - base09), 32'd0);

        // Channel toggled mid-word: word completes from 0.9, next word from 2.4.
        base09 = pulls09;
        base24 = pulls24;
        channel_sel = 1'b0;
        load(1'b0, 32'hCAFEBABE);
        load(1'b1, 32'h0BADF00D);
        expect_word(32'hCAFEBABE);
        expect_word(32'h0BADF00D);
        wait_req();
        repeat (2) strobe_byte();
        channel_sel = 1'b1;
        repeat (6) strobe_byte();
        repeat (4) @(negedge clk);
        check_idle("t3_end");
        check("t3_pulls09", 32'(pulls09 - base09), 32'd1);
        check("t3_pulls24", 32'(pulls24 - base24), 32'd1);

        // Underrun: strobe in IDLE, clear alone, then clear coincident with a new set.
        soe_n = 1'b0;
        repeat (3) @(negedge clk);
        soe_n = 1'b1;
        repeat (6) @(negedge clk);
        check("ur_set",  32'(underrun), 32'd1);
        check("ur_data", 32'(data_out), 32'd0);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        @(negedge clk);
        check("ur_clr", 32'(underrun), 32'd0);
        soe_n = 1'b0;
        repeat (3) @(negedge clk);
        soe_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ur_pre", 32'(underrun), 32'd0);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("ur_set_wins", 32'(underrun), 32'd1);
        repeat (3) @(negedge clk);
        check("ur_sticky", 32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        @(negedge clk);
        check("ur_clr2", 32'(underrun), 32'd0);

        // Reset after the first byte: partial word dropped, next word restarts at byte 0.
        channel_sel = 1'b0;
        load(1'b0, 32'hDEADBEEF);
        load(1'b0, 32'h01234567);
        exp_q.push_back(8'hEF);
        wait_req();
        strobe_byte();
        base09 = pulls09;
        base24 = pulls24;
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_data",     32'(data_out),    32'd0);
        check("mid_rst_req",      32'(read_req),    32'd0);
        check("mid_rst_underrun", 32'(underrun),    32'd0);
        check("mid_rst_pull09",   32'(fifo09_pull), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_nopull09", 32'(pulls09 - base09), 32'd0);
        check("mid_rst_nopull24", 32'(pulls24 - base24), 32'd0);
        expect_word(32'h01234567);
        reset_n = 1'b1;
        wait_req();
        repeat (4) strobe_byte();
        repeat (4) @(negedge clk);
        check_idle("t5_end");
        check("t5_underrun", 32'(underrun), 32'd0);
        check("t5_pulls09",  32'(pulls09 - base09), 32'd1);
        check("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/smi_fifo_reader.md
SMI_FIFO_READER -- requirements
Module: smi_fifo_reader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in the SOE strobe synchronizer (legal range 2..4).
REQ-002 SHALL have port i_sys_clk, input, 1 bit: the single FPGA system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_channel_sel, input, 1 bit: source select, 0 = 0.9 GHz FIFO, 1 = 2.4 GHz FIFO.
REQ-005 SHALL have port o_fifo_09_pull, output, 1 bit: single-cycle read pulse to the 0.9 GHz FIFO.
REQ-006 SHALL have port i_fifo_09_pulled_data, input, 32 bits: 0.9 GHz FIFO read data, valid one cycle after the pull.
REQ-007 SHALL have port i_fifo_09_empty, input, 1 bit: 0.9 GHz FIFO empty flag.
REQ-008 SHALL have ports o_fifo_24_pull (output, 1), i_fifo_24_pulled_data (input, 32) and i_fifo_24_empty (input, 1), with the same meanings for the 2.4 GHz FIFO.
REQ-009 SHALL have port i_smi_soe_se, input, 1 bit: asynchronous SMI read strobe, active-low.
REQ-010 SHALL have port o_smi_data_out, output, 8 bits: the byte currently presented on the SMI bus.
REQ-011 SHALL have port o_smi_read_req, output, 1 bit: a complete word is loaded and bytes are available.
REQ-012 SHALL have port i_underrun_clr, input, 1 bit: a single-cycle clear of the underrun flag.
REQ-013 SHALL have port o_underrun, output, 1 bit: sticky flag, set when the host strobes with no data loaded.

Function
REQ-014 SHALL implement FSM states IDLE, PULL, WAIT, LOAD and SHIFT.
REQ-015 IDLE: SHALL latch i_channel_sel into the active channel; if that channel's FIFO is not empty -> PULL, else stay in IDLE.
REQ-016 PULL: SHALL assert only the active channel's pull for exactly one cycle -> WAIT.
REQ-017 WAIT: SHALL wait one cycle for the FIFO read latency -> LOAD.
REQ-018 LOAD: SHALL capture the active channel's 32-bit data into the shift register, set byte index to 0 and set o_smi_read_req=1 -> SHIFT.
REQ-019 SHIFT: o_smi_data_out SHALL equal word[8*idx+7:8*idx], i.e. LSB byte first.
REQ-020 In SHIFT, each synchronized rising edge of i_smi_soe_se (end of the host read) SHALL increment idx.
REQ-021 On the edge that consumes idx 3, SHALL clear o_smi_read_req, latch i_channel_sel, and go to PULL if the newly selected FIFO is non-empty, else to IDLE.
REQ-022 Latency SHALL be 3 cycles: an empty flag low at cycle 0 in IDLE gives pull at cycle 1 and o_smi_read_req=1 at cycle 3.
REQ-023 A change of i_channel_sel mid-word SHALL be ignored until the word boundary; words SHALL never mix channels.
REQ-024 Pull SHALL never be asserted outside PULL, never to both FIFOs in the same cycle, and never to an empty FIFO.
REQ-025 A strobe rising edge outside SHIFT SHALL set o_underrun; o_smi_data_out SHALL read 0x00 outside SHIFT.
REQ-026 If set and clear occur in the same cycle, o_underrun SHALL stay 1 (set wins).
REQ-027 Strobe edges closer than SYNC_STAGES+1 cycles apart need not be resolved; the host timing guarantees at least 4-cycle spacing.

Reset
REQ-028 While i_reset_n=0 at a clock edge, SHALL force: state=IDLE, both pulls=0, o_smi_data_out=0x00, o_smi_read_req=0, o_underrun=0, idx=0, active channel=0, synchronizer flops=1 (strobe inactive).
REQ-029 Reset mid-word SHALL discard the partial word, issue no further pull, and on release SHALL not produce a spurious strobe edge.

Structure
REQ-030 Shared package smi_pkg SHALL hold the FSM state encoding, BYTES_PER_WORD=4, and the channel codes CH_09=0 and CH_24=1.
REQ-031 SHALL instantiate one sub-module, smi_strobe_sync, containing the SYNC_STAGES synchronizer plus rising-edge detector and outputting a one-cycle pulse.

Verification
REQ-032 Reset then fifo_09 holding 0xA1B2C3D4, channel 0 -> one 09 pull, read_req at cycle 3, bytes D4,C3,B2,A1 over 4 strobes, then back to IDLE.
REQ-033 fifo_24 holding two words 0x11223344 and 0x55667788, channel 1 -> 8 strobes give 44,33,22,11,88,77,66,55; exactly 2 pulls on 24 and 0 on 09.
REQ-034 Toggle i_channel_sel after the 2nd byte -> the current word completes from its original FIFO, and the next pull goes to the new FIFO.
REQ-035 Strobe while in IDLE -> o_underrun=1 and data 0x00; assert i_underrun_clr alone -> o_underrun=0; assert clear together with a new underrun -> o_underrun=1.
REQ-036 i_reset_n=0 after byte 1 -> all outputs reset per REQ-028, no pull during reset, and the next word restarts at byte 0.
